// File: rtl/hwpe_stream_rr_buffer_arbiter.sv
// Round-robin arbiter sharing one registered HWPE-Stream stage between NB_IN sink streams.
// Define HWPE_STREAM_ARB_BURST_EN to lock the grant on one input for burst_len_i beats.
module hwpe_stream_rr_buffer_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NB_IN      = 4
`ifdef HWPE_STREAM_ARB_BURST_EN
  , parameter int unsigned CNT_WIDTH = 8
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         enable_i,
  input  logic [NB_IN-1:0]             push_valid_i,
  output logic [NB_IN-1:0]             push_ready_o,
  input  logic [NB_IN*DATA_WIDTH-1:0]  push_data_i,
  input  logic [NB_IN*DATA_WIDTH/8-1:0] push_strb_i,
  output logic                         pop_valid_o,
  input  logic                         pop_ready_i,
  output logic [DATA_WIDTH-1:0]        pop_data_o,
  output logic [DATA_WIDTH/8-1:0]      pop_strb_o,
  output logic [NB_IN-1:0]             grant_o
`ifdef HWPE_STREAM_ARB_BURST_EN
  , input logic [CNT_WIDTH-1:0]        burst_len_i
`endif
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned PW = (NB_IN > 1) ? $clog2(NB_IN) : 1;

  logic [PW-1:0]         ptr_q, sel, sel_inc, idx;
  logic [PW:0]           idx_w;
  logic                  ld, hs, any_grant;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [SW-1:0]         strb_sel;
  logic                  lock_q;
  logic [PW-1:0]         lock_idx_q;

`ifdef HWPE_STREAM_ARB_BURST_EN
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_start;
  assign cnt_start = (burst_len_i == '0) ? '0 : burst_len_i - 1'b1;
`else
  assign lock_q     = 1'b0;
  assign lock_idx_q = '0;
`endif

  assign ld      = ~pop_valid_o | pop_ready_i;
  assign sel_inc = (sel == PW'(NB_IN - 1)) ? '0 : sel + 1'b1;

  // Scan from ptr_q with wrap; a locked burst overrides the scan even without valid.
  always_comb begin
    grant_o   = '0;
    sel       = '0;
    any_grant = 1'b0;
    idx_w     = '0;
    idx       = '0;
    if (enable_i) begin
      if (lock_q) begin
        sel       = lock_idx_q;
        any_grant = 1'b1;
      end else begin
        for (int i = 0; i < NB_IN; i++) begin
          idx_w = {1'b0, ptr_q} + (PW+1)'(i);
          if (idx_w >= (PW+1)'(NB_IN)) idx_w = idx_w - (PW+1)'(NB_IN);
          idx = idx_w[PW-1:0];
          if (!any_grant && push_valid_i[idx]) begin
            any_grant = 1'b1;
            sel       = idx;
          end
        end
      end
      if (any_grant) grant_o[sel] = 1'b1;
    end
  end

  always_comb begin
    data_sel = '0;
    strb_sel = '0;
    for (int k = 0; k < NB_IN; k++) begin
      if (sel == PW'(k)) begin
        data_sel = push_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        strb_sel = push_strb_i[k*SW +: SW];
      end
    end
  end

  assign push_ready_o = grant_o & {NB_IN{ld}};
  assign hs           = any_grant & ld & push_valid_i[sel];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pop_valid_o <= 1'b0;
      pop_data_o  <= '0;
      pop_strb_o  <= '0;
    end else if (clear_i) begin
      pop_valid_o <= 1'b0;
      pop_data_o  <= '0;
      pop_strb_o  <= '0;
    end else if (ld) begin
      pop_valid_o <= hs;
      if (hs) begin
        pop_data_o <= data_sel;
        pop_strb_o <= strb_sel;
      end
    end
  end

`ifdef HWPE_STREAM_ARB_BURST_EN
  // cnt_q holds the beats still owed after the current one; the last beat releases the lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else if (clear_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else if (hs) begin
      if (lock_q) begin
        if (cnt_q == CNT_WIDTH'(1)) begin
          lock_q <= 1'b0;
          cnt_q  <= '0;
          ptr_q  <= sel_inc;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end else if (cnt_start == '0) begin
        ptr_q <= sel_inc;
      end else begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
        cnt_q      <= cnt_start;
      end
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (clear_i) begin
      ptr_q <= '0;
    end else if (hs) begin
      ptr_q <= sel_inc;
    end
  end
`endif

endmodule

// File: tb/tb_hwpe_stream_rr_buffer_arbiter.sv
// Randomized and directed bench for hwpe_stream_rr_buffer_arbiter against a queue-based reference model.
module tb_hwpe_stream_rr_buffer_arbiter;
  localparam int NB = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic enable = 1'b0;
  logic pop_ready = 1'b0;
  logic [NB-1:0] push_valid, push_ready, grant;
  logic [NB*DW-1:0] push_data;
  logic [NB*SW-1:0] push_strb;
  logic pop_valid;
  logic [DW-1:0] pop_data;
  logic [SW-1:0] pop_strb;
`ifdef HWPE_STREAM_ARB_BURST_EN
  logic [7:0] burst_len = 8'd0;
`endif

  hwpe_stream_rr_buffer_arbiter #(.DATA_WIDTH(DW), .NB_IN(NB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
    .push_valid_i(push_valid), .push_ready_o(push_ready),
    .push_data_i(push_data), .push_strb_i(push_strb),
    .pop_valid_o(pop_valid), .pop_ready_i(pop_ready),
    .pop_data_o(pop_data), .pop_strb_o(pop_strb),
    .grant_o(grant)
`ifdef HWPE_STREAM_ARB_BURST_EN
    , .burst_len_i(burst_len)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src_q[NB][$];
  logic [DW-1:0] log_q[$];
  int checks = 0;
  int passed = 0;

  // reference model state
  int m_ptr = 0;
  bit m_valid = 0;
  logic [DW-1:0] m_data = '0;
  logic [SW-1:0] m_strb = '0;
  bit m_lock = 0;
  int m_lk = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive();
    for (int k = 0; k < NB; k++) begin
      logic [DW-1:0] d;
      d = (src_q[k].size() > 0) ? src_q[k][0] : '0;
      push_valid[k] = src_q[k].size() > 0;
      push_data[k*DW +: DW] = d;
      push_strb[k*SW +: SW] = d[SW-1:0];
    end
  endtask

  task automatic model_step();
    int g;
    bit ld, hs;
    logic [NB-1:0] eg;
    logic [DW-1:0] beat;
    g = -1;
    eg = '0;
    beat = '0;
    if (enable) begin
      if (m_lock) g = m_lk;
      else
        for (int i = 0; i < NB; i++)
          if (g < 0 && push_valid[(m_ptr + i) % NB]) g = (m_ptr + i) % NB;
    end
    if (g >= 0) eg[g] = 1'b1;
    ld = !m_valid || pop_ready;
    chk("grant", grant, eg);
    chk("push_ready", push_ready, ld ? eg : '0);
    chk("pop_valid", pop_valid, m_valid);
    chk("pop_data", pop_data, m_data);
    chk("pop_strb", pop_strb, m_strb);
    if (pop_valid && pop_ready) log_q.push_back(pop_data);
    hs = (g >= 0) && ld && push_valid[g];
    if (hs) beat = src_q[g].pop_front();
    if (!rst_n || clear) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_strb = '0; m_lock = 0; m_cnt = 0;
    end else begin
      if (ld) begin
        m_valid = hs;
        if (hs) begin m_data = beat; m_strb = beat[SW-1:0]; end
      end
      if (hs) begin
`ifdef HWPE_STREAM_ARB_BURST_EN
        if (m_lock) begin
          if (m_cnt == 1) begin m_lock = 0; m_cnt = 0; m_ptr = (g + 1) % NB; end
          else m_cnt--;
        end else if (burst_len <= 1) m_ptr = (g + 1) % NB;
        else begin m_lock = 1; m_lk = g; m_cnt = int'(burst_len) - 1; end
`else
        m_ptr = (g + 1) % NB;
`endif
      end
    end
  endtask

  task automatic cyc();
    drive();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input string name, input int n, input int max_cyc);
    int c = 0;
    while (log_q.size() < n && c < max_cyc) begin cyc(); c++; end
    chk({"timeout_", name}, 64'(log_q.size() >= n), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] held;
    drive();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("reset_pop_valid", pop_valid, 0);
    chk("reset_grant", grant, 0);
    chk("reset_push_ready", push_ready, 0);

    // single requester on input 2
    enable = 1; pop_ready = 1;
    for (int i = 0; i < 8; i++) src_q[2].push_back(32'hA0 + i);
    cyc(); cyc();
    chk("latency_first_beat", log_q.size(), 1);
    run_until("single", 8, 40);
    for (int i = 0; i < 8; i++) chk("single_order", log_q[i], 32'hA0 + i);

    // clear with a pending output beat
    pop_ready = 0;
    src_q[0].push_back(32'h77);
    cyc(); cyc();
    chk("pre_clear_valid", pop_valid, 1);
    clear = 1; cyc(); clear = 0; cyc();
    chk("clear_pop_valid", pop_valid, 0);

    // round robin from pointer 0 after clear
    log_q.delete(); pop_ready = 1;
    for (int r = 0; r < 2; r++) for (int k = 0; k < NB; k++) src_q[k].push_back(32'h10 + k);
    run_until("rr", 8, 40);
    for (int i = 0; i < 8; i++) chk("rr_order", log_q[i], 32'h10 + (i % 4));

    // pointer after input 1 served
    log_q.delete();
    src_q[1].push_back(32'h31);
    run_until("ptr_a", 1, 20);
    src_q[0].push_back(32'h30);
    src_q[3].push_back(32'h33);
    run_until("ptr_b", 3, 20);
    chk("ptr_0", log_q[0], 32'h31);
    chk("ptr_1", log_q[1], 32'h33);
    chk("ptr_2", log_q[2], 32'h30);

    // backpressure mid-stream, pointer starts at 1
    log_q.delete();
    for (int r = 0; r < 4; r++) for (int k = 0; k < NB; k++) src_q[k].push_back(32'h100 + r * 16 + k);
    repeat (6) cyc();
    pop_ready = 0;
    cyc();
    held = pop_data;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stable", pop_data, held);
      chk("bp_no_ready", push_ready, 0);
      cyc();
    end
    pop_ready = 1;
    run_until("bp", 16, 60);
    for (int i = 0; i < 16; i++) chk("bp_order", log_q[i], 32'h100 + (i / 4) * 16 + ((1 + i) % 4));

    // enable drop: pending beat drains, no new handshakes
    log_q.delete(); pop_ready = 0;
    src_q[2].push_back(32'h200); src_q[2].push_back(32'h201);
    cyc(); cyc();
    enable = 0;
    repeat (3) begin chk("dis_no_ready", push_ready, 0); cyc(); end
    pop_ready = 1;
    cyc(); cyc();
    chk("dis_drain_cnt", log_q.size(), 1);
    chk("dis_drain_val", pop_valid, 0);
    enable = 1;
    run_until("dis_resume", 2, 20);
    chk("dis_first", log_q[0], 32'h200);
    chk("dis_second", log_q[1], 32'h201);

`ifdef HWPE_STREAM_ARB_BURST_EN
    clear = 1; cyc(); clear = 0;
    log_q.delete(); burst_len = 8'd3;
    for (int i = 0; i < 3; i++) begin src_q[0].push_back(32'hB0 + i); src_q[1].push_back(32'hC0 + i); end
    run_until("burst", 6, 40);
    for (int i = 0; i < 6; i++) chk("burst_order", log_q[i], (i < 3) ? 32'hB0 + i : 32'hC0 + i - 3);
    clear = 1; cyc(); clear = 0;
    log_q.delete();
    src_q[0].push_back(32'hD0); src_q[1].push_back(32'hE0);
    cyc(); cyc();
    repeat (4) begin chk("burst_stall_grant", grant, 4'b0001); cyc(); end
    chk("burst_stall_cnt", log_q.size(), 1);
    src_q[0].push_back(32'hD1); src_q[0].push_back(32'hD2);
    run_until("burst_stall", 4, 20);
    chk("burst_stall_3", log_q[3], 32'hE0);
    chk("burst_stall_2", log_q[2], 32'hD2);
`endif

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      pop_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 49) == 0);
`ifdef HWPE_STREAM_ARB_BURST_EN
      burst_len = 8'($urandom_range(0, 4));
`endif
      for (int k = 0; k < NB; k++)
        if ($urandom_range(0, 2) == 0 && src_q[k].size() < 4) src_q[k].push_back($urandom);
      log_q.delete();
      cyc();
    end
    clear = 0; enable = 1; pop_ready = 1;
    begin
      int c = 0;
      while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0 || pop_valid) && c < 200) begin
        cyc(); c++;
      end
    end
    chk("drain_empty", 64'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
